axis_data_checker: RTL and testbench

- AXI-Stream sink that consumes frames from the pattern-generator stream and checks them beat by beat.
- Checks data pattern, tkeep, tlast position against the configured length, and abort marking (tuser).
- Sits at the receive end of loopback/RoCE datapath tests and exposes per-frame results and saturating statistics to a register block.

---
 rtl/axis_data_pkg.sv | 17 +
 rtl/axis_pattern_ref.sv | 19 +
 rtl/axis_data_checker.sv | 120 ++++++++++++
 tb/tb_axis_data_checker.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_data_pkg.sv
// axis_data_pkg: shared types, flag indices and the keep-mask helper used by checker and generator.
package axis_data_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    localparam int ERR_DATA  = 0;
    localparam int ERR_KEEP  = 1;
    localparam int ERR_SHORT = 2;
    localparam int ERR_LONG  = 3;
    localparam logic [31:0] FILLER = 32'hDEADBEEF;
    localparam int MAX_W = 256;
    // A zero remainder only occurs for zero-length frames, whose single beat expects full keep.
    function automatic logic [MAX_W-1:0] keep_mask(input logic [31:0] rem, input int w);
        logic [MAX_W-1:0] m;
        for (int i = 0; i < MAX_W; i++)
            m[i] = (rem == 0 || rem >= w) ? (i < w) : (i < rem);
        return m;
    endfunction
endpackage

// File: rtl/axis_pattern_ref.sv
// axis_pattern_ref: combinational expected tdata/tkeep/last-beat for a beat at byte offset off_i.
module axis_pattern_ref
    import axis_data_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [31:0]             off_i,
    input  logic [31:0]             len_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [DATA_WIDTH/8-1:0] keep_o,
    output logic                    last_o
);
    localparam int W = DATA_WIDTH / 8;
    assign last_o = ({1'b0, off_i} + 33'(W)) >= {1'b0, len_i};
    assign keep_o = last_o ? W'(keep_mask(len_i - off_i, W)) : '1;
    for (genvar i = 0; i < DATA_WIDTH / 32; i++) begin : g_slice
        assign data_o[32*i +: 32] = (i == 0) ? off_i : (i == 1) ? ~off_i : FILLER;
    end
endmodule

// File: rtl/axis_data_checker.sv
// axis_data_checker: AXI-Stream sink checking pattern, keep, length and abort per frame, with stats.
// Define AXIS_CHECKER_BACKPRESSURE_EN to throttle tready with a free-running LFSR.
module axis_data_checker
    import axis_data_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    input  logic                    enable,
    input  logic [31:0]             length,
    input  logic                    clear_stats,
    output logic                    frame_done,
    output logic                    frame_ok,
    output logic                    frame_aborted,
    output logic [3:0]              frame_err_flags,
    output logic [31:0]             frame_count,
    output logic [31:0]             error_count,
    output logic [31:0]             abort_count,
    output logic [63:0]             byte_count
);
    localparam int W = DATA_WIDTH / 8;
    state_e state_q, state_d;
    logic [31:0] off_q, off_d, len_q, len_d, off_cur, len_cur;
    logic [31:0] frame_q, frame_d, error_q, error_d, abcnt_q, abcnt_d;
    logic [63:0] bytes_q, bytes_d;
    logic [3:0] flags_q, flags_d, beat_flags, flags_new, err_q;
    logic abort_q, abort_d, done_q, ok_q, aborted_q;
    logic idle, acc, done, abort_any, chk;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [W-1:0] exp_keep;
    logic exp_last;
`ifdef AXIS_CHECKER_BACKPRESSURE_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) lfsr_q <= 16'hACE1;
        else lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign s_axis_tready = rst && enable && lfsr_q[0];
`else
    assign s_axis_tready = rst && enable;
`endif
    // The first beat of a frame is checked against the live length input and offset zero.
    assign idle      = state_q == IDLE;
    assign off_cur   = idle ? 32'd0 : off_q;
    assign len_cur   = idle ? length : len_q;
    assign acc       = s_axis_tvalid && s_axis_tready;
    assign done      = acc && s_axis_tlast;
    assign abort_any = s_axis_tuser || (!idle && abort_q);
    assign chk       = state_q != DRAIN && !abort_any;
    axis_pattern_ref #(.DATA_WIDTH(DATA_WIDTH)) u_ref (
        .off_i (off_cur),
        .len_i (len_cur),
        .data_o(exp_data),
        .keep_o(exp_keep),
        .last_o(exp_last)
    );
    always_comb begin
        beat_flags = '0;
        beat_flags[ERR_DATA]  = chk && s_axis_tdata != exp_data;
        beat_flags[ERR_KEEP]  = chk && s_axis_tkeep != exp_keep;
        beat_flags[ERR_SHORT] = chk && s_axis_tlast && !exp_last;
        beat_flags[ERR_LONG]  = chk && exp_last && !s_axis_tlast;
    end
    assign flags_new = beat_flags | (idle ? 4'b0 : flags_q);
    assign state_d = !acc ? state_q : s_axis_tlast ? IDLE : (state_q == DRAIN || exp_last) ? DRAIN : RUN;
    assign off_d   = acc ? off_cur + 32'(W) : off_q;
    assign len_d   = acc && idle ? length : len_q;
    assign flags_d = acc ? flags_new : flags_q;
    assign abort_d = acc ? abort_any : abort_q;
    // Clearing takes priority, so a completion in the same cycle is not counted.
    assign frame_d = clear_stats ? '0 : frame_q + 32'(done);
    assign error_d = clear_stats ? '0 : error_q + 32'(done && !abort_any && |flags_new && error_q != '1);
    assign abcnt_d = clear_stats ? '0 : abcnt_q + 32'(done && abort_any && abcnt_q != '1);
    assign bytes_d = clear_stats ? '0 : bytes_q + (acc ? 64'($countones(s_axis_tkeep)) : 64'd0);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            off_q     <= '0;
            len_q     <= '0;
            flags_q   <= '0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= '0;
            frame_q   <= '0;
            error_q   <= '0;
            abcnt_q   <= '0;
            bytes_q   <= '0;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            len_q     <= len_d;
            flags_q   <= flags_d;
            abort_q   <= abort_d;
            done_q    <= done;
            ok_q      <= done && !abort_any && flags_new == 4'b0;
            aborted_q <= done && abort_any;
            err_q     <= done ? flags_new : 4'b0;
            frame_q   <= frame_d;
            error_q   <= error_d;
            abcnt_q   <= abcnt_d;
            bytes_q   <= bytes_d;
        end
    end
    assign frame_done      = done_q;
    assign frame_ok        = ok_q;
    assign frame_aborted   = aborted_q;
    assign frame_err_flags = err_q;
    assign frame_count     = frame_q;
    assign error_count     = error_q;
    assign abort_count     = abcnt_q;
    assign byte_count      = bytes_q;
endmodule

// File: tb/tb_axis_data_checker.sv
// tb_axis_data_checker: directed self-checking bench for axis_data_checker at DATA_WIDTH=64.
module tb_axis_data_checker;
    logic clk = 1'b0, rst = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
    logic enable = 1'b0, clear_stats = 1'b0;
    logic [31:0] length = '0;
    logic frame_done, frame_ok, frame_aborted;
    logic [3:0] frame_err_flags;
    logic [31:0] frame_count, error_count, abort_count;
    logic [63:0] byte_count;
    int compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    axis_data_checker #(.DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .enable(enable), .length(length), .clear_stats(clear_stats),
        .frame_done(frame_done), .frame_ok(frame_ok), .frame_aborted(frame_aborted),
        .frame_err_flags(frame_err_flags), .frame_count(frame_count), .error_count(error_count),
        .abort_count(abort_count), .byte_count(byte_count)
    );

    function automatic logic [63:0] pat(input logic [31:0] off);
        return {~off, off};
    endfunction

    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        int n = 0;
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u; s_axis_tvalid = 1'b1;
        @(posedge clk);
        while (!s_axis_tready && n < 50) begin n++; @(posedge clk); end
        if (n >= 50) begin compared++; mismatched++; $display("FAIL tready_timeout: tready stayed %0b, want 1", s_axis_tready); end
        #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared++; if (s_axis_tready !== 1'b0) begin mismatched++; $display("FAIL reset_tready: got %0b want 0", s_axis_tready); end
        compared++; if ({frame_done, frame_ok, frame_aborted, frame_err_flags} !== 7'b0) begin mismatched++; $display("FAIL reset_frame_outs: got %b want 0", {frame_done, frame_ok, frame_aborted, frame_err_flags}); end
        compared++; if ({frame_count, error_count, abort_count, byte_count} !== 160'b0) begin mismatched++; $display("FAIL reset_counters: got %h want 0", {frame_count, error_count, abort_count, byte_count}); end
        rst = 1'b1;
        #1;
        compared++; if (s_axis_tready !== 1'b1) begin mismatched++; $display("FAIL run_tready: got %0b want 1", s_axis_tready); end
    endtask

    task automatic test_clean64();
        length = 64;
        for (int b = 0; b < 8; b++) begin
            send(pat(32'(b * 8)), 8'hFF, b == 7, 1'b0);
            if (b == 6) begin compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL clean_early_done: got %0b want 0", frame_done); end end
        end
        compared++; if ({frame_done, frame_ok, frame_aborted, frame_err_flags} !== 7'b1100000) begin mismatched++; $display("FAIL clean_result: got %b want 1100000", {frame_done, frame_ok, frame_aborted, frame_err_flags}); end
        compared++; if (frame_count !== 32'd1) begin mismatched++; $display("FAIL clean_frame_count: got %0d want 1", frame_count); end
        compared++; if (byte_count !== 64'd64) begin mismatched++; $display("FAIL clean_byte_count: got %0d want 64", byte_count); end
        @(posedge clk); #1;
        compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL done_pulse_width: got %0b want 0", frame_done); end
    endtask

    task automatic test_len13();
        pulse_clear();
        length = 13;
        send(pat(0), 8'hFF, 1'b0, 1'b0);
        send(pat(8), 8'h1F, 1'b1, 1'b0);
        compared++; if ({frame_done, frame_ok, frame_err_flags} !== 6'b110000) begin mismatched++; $display("FAIL len13_result: got %b want 110000", {frame_done, frame_ok, frame_err_flags}); end
        compared++; if (byte_count !== 64'd13) begin mismatched++; $display("FAIL len13_bytes: got %0d want 13", byte_count); end
    endtask

    task automatic test_back_to_back();
        pulse_clear();
        length = 13;
        send(pat(0), 8'hFF, 1'b0, 1'b0);
        send(pat(8), 8'h1F, 1'b1, 1'b0);
        send(pat(0), 8'hFF, 1'b0, 1'b0);
        compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL b2b_gap_done: got %0b want 0", frame_done); end
        send(pat(8), 8'h1F, 1'b1, 1'b0);
        compared++; if ({frame_done, frame_ok, frame_count} !== {2'b11, 32'd2}) begin mismatched++; $display("FAIL b2b_result: got %b/%0d want 11/2", {frame_done, frame_ok}, frame_count); end
        compared++; if (byte_count !== 64'd26) begin mismatched++; $display("FAIL b2b_bytes: got %0d want 26", byte_count); end
    endtask

    task automatic test_data_err();
        pulse_clear();
        length = 32;
        send(pat(0), 8'hFF, 1'b0, 1'b0);
        send(pat(8), 8'hFF, 1'b0, 1'b0);
        send({~32'd16, 32'd17}, 8'hFF, 1'b0, 1'b0);
        send(pat(24), 8'hFF, 1'b1, 1'b0);
        compared++; if ({frame_done, frame_ok, frame_err_flags} !== 6'b100001) begin mismatched++; $display("FAIL data_err_result: got %b want 100001", {frame_done, frame_ok, frame_err_flags}); end
        compared++; if (error_count !== 32'd1) begin mismatched++; $display("FAIL data_err_count: got %0d want 1", error_count); end
    endtask

    task automatic test_short();
        pulse_clear();
        length = 64;
        send(pat(0), 8'hFF, 1'b0, 1'b0);
        send(pat(8), 8'hFF, 1'b0, 1'b0);
        send(pat(16), 8'hFF, 1'b1, 1'b0);
        compared++; if ({frame_done, frame_ok, frame_err_flags} !== 6'b100100) begin mismatched++; $display("FAIL short_result: got %b want 100100", {frame_done, frame_ok, frame_err_flags}); end
    endtask

    task automatic test_long();
        pulse_clear();
        length = 64;
        for (int b = 0; b < 10; b++) begin
            send(b < 8 ? pat(32'(b * 8)) : 64'd0, 8'hFF, b == 9, 1'b0);
            if (b == 7) begin compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL long_done_at_beat7: got %0b want 0", frame_done); end end
        end
        compared++; if ({frame_done, frame_ok, frame_err_flags} !== 6'b101000) begin mismatched++; $display("FAIL long_result: got %b want 101000", {frame_done, frame_ok, frame_err_flags}); end
        compared++; if ({error_count, byte_count} !== {32'd1, 64'd80}) begin mismatched++; $display("FAIL long_counts: got err %0d bytes %0d want 1/80", error_count, byte_count); end
    endtask

    task automatic test_abort();
        pulse_clear();
        length = 64;
        for (int b = 0; b < 3; b++) send(pat(32'(b * 8)), 8'hFF, 1'b0, 1'b0);
        send(64'hBAD, 8'h01, 1'b1, 1'b1);
        compared++; if ({frame_done, frame_ok, frame_aborted, frame_err_flags} !== 7'b1010000) begin mismatched++; $display("FAIL abort_result: got %b want 1010000", {frame_done, frame_ok, frame_aborted, frame_err_flags}); end
        compared++; if ({abort_count, error_count} !== {32'd1, 32'd0}) begin mismatched++; $display("FAIL abort_counts: got abort %0d err %0d want 1/0", abort_count, error_count); end
    endtask

    task automatic test_len0();
        pulse_clear();
        length = 0;
        send(pat(0), 8'h0F, 1'b1, 1'b0);
        compared++; if ({frame_done, frame_ok, frame_err_flags} !== 6'b100010) begin mismatched++; $display("FAIL len0_keep: got %b want 100010", {frame_done, frame_ok, frame_err_flags}); end
        send(pat(0), 8'hFF, 1'b1, 1'b0);
        compared++; if ({frame_done, frame_ok, frame_err_flags} !== 6'b110000) begin mismatched++; $display("FAIL len0_ok: got %b want 110000", {frame_done, frame_ok, frame_err_flags}); end
    endtask

    task automatic test_enable_stall();
        pulse_clear();
        length = 24;
        send(pat(0), 8'hFF, 1'b0, 1'b0);
        enable = 1'b0;
        #1;
        compared++; if (s_axis_tready !== 1'b0) begin mismatched++; $display("FAIL stall_tready: got %0b want 0", s_axis_tready); end
        s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; s_axis_tdata = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        compared++; if ({frame_done, frame_count, byte_count} !== {1'b0, 32'd0, 64'd8}) begin mismatched++; $display("FAIL stall_hold: got done %0b frames %0d bytes %0d want 0/0/8", frame_done, frame_count, byte_count); end
        enable = 1'b1;
        send(pat(8), 8'hFF, 1'b0, 1'b0);
        send(pat(16), 8'hFF, 1'b1, 1'b0);
        compared++; if ({frame_done, frame_ok, frame_err_flags} !== 6'b110000) begin mismatched++; $display("FAIL stall_resume: got %b want 110000", {frame_done, frame_ok, frame_err_flags}); end
    endtask

    task automatic test_reset_mid();
        pulse_clear();
        length = 64;
        for (int b = 0; b < 4; b++) send(pat(32'(b * 8)), 8'hFF, 1'b0, 1'b0);
        s_axis_tdata = pat(32); s_axis_tkeep = 8'hFF; s_axis_tvalid = 1'b1;
        #2 rst = 1'b0;
        #1;
        compared++; if ({frame_done, s_axis_tready, byte_count} !== 66'b0) begin mismatched++; $display("FAIL midreset_clear: got done %0b rdy %0b bytes %0d want 0/0/0", frame_done, s_axis_tready, byte_count); end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0; rst = 1'b1;
        length = 16;
        send(pat(0), 8'hFF, 1'b0, 1'b0);
        send(pat(8), 8'hFF, 1'b1, 1'b0);
        compared++; if ({frame_done, frame_ok, frame_err_flags, frame_count} !== {6'b110000, 32'd1}) begin mismatched++; $display("FAIL midreset_next: got %b frames %0d want 110000/1", {frame_done, frame_ok, frame_err_flags}, frame_count); end
    endtask

    task automatic test_clear_coincide();
        length = 16;
        send(pat(0), 8'hFF, 1'b0, 1'b0);
        clear_stats = 1'b1;
        send(pat(8), 8'hFF, 1'b1, 1'b0);
        clear_stats = 1'b0;
        compared++; if (frame_done !== 1'b1) begin mismatched++; $display("FAIL clear_done: got %0b want 1", frame_done); end
        compared++; if ({frame_count, error_count, abort_count, byte_count} !== 160'b0) begin mismatched++; $display("FAIL clear_counters: got %h want 0", {frame_count, error_count, abort_count, byte_count}); end
    endtask

    initial begin
        test_reset();
        test_clean64();
        test_len13();
        test_back_to_back();
        test_data_err();
        test_short();
        test_long();
        test_abort();
        test_len0();
        test_enable_stall();
        test_reset_mid();
        test_clear_coincide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
